// File: rtl/cell_bist.sv
// cell_bist: exhaustive BIST sequencer for one combinational standard cell.
// Define CELL_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module cell_bist #(
  parameter int                     NIN    = 1,
  parameter logic [(1<<NIN)-1:0]    TRUTH  = 2'b01,
  parameter int                     SETTLE = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  output logic [NIN-1:0] cell_in,
  input  logic           cell_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [NIN:0]   err_count,
  output logic           fail_valid,
  output logic [NIN-1:0] fail_vec,
  output logic           fail_got
);

  localparam int NV = 1 << NIN;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]  SRELOAD = SW'(SETTLE - 1);
  localparam logic [NIN-1:0] VLAST   = NIN'(NV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [NIN-1:0] vec_q, vec_d;
  logic [NIN-1:0] cell_in_q, cell_in_d;
  logic [SW-1:0]  scnt_q, scnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [NIN:0]   err_q, err_d;
  logic           fvalid_q, fvalid_d;
  logic [NIN-1:0] fvec_q, fvec_d;
  logic           fgot_q, fgot_d;

  logic launch;
  logic mism;
  logic last;

  assign launch = start &&
                  (state_q == S_IDLE || state_q == S_DONE);
  // Case inequality so X/Z on the cell output counts as a failure.
  assign mism   = (cell_out !== TRUTH[vec_q]);
  assign last   = (vec_q == VLAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      cell_in_q <= '0;
      scnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fvalid_q  <= 1'b0;
      fvec_q    <= '0;
      fgot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cell_in_q <= cell_in_d;
      scnt_q    <= scnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fvalid_q  <= fvalid_d;
      fvec_q    <= fvec_d;
      fgot_q    <= fgot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_DONE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt_q == '0) state_d = S_CHECK;
      end
      S_CHECK: begin
`ifdef CELL_BIST_STOP_ON_FAIL_EN
        state_d = (mism || last) ? S_DONE : S_SETTLE;
`else
        state_d = last ? S_DONE : S_SETTLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vec_d     = vec_q;
    cell_in_d = cell_in_q;
    scnt_d    = scnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fvalid_d  = fvalid_q;
    fvec_d    = fvec_q;
    fgot_d    = fgot_q;
    if (launch) begin
      vec_d     = '0;
      cell_in_d = '0;
      scnt_d    = SRELOAD;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      err_d     = '0;
      fvalid_d  = 1'b0;
      fvec_d    = '0;
      fgot_d    = 1'b0;
    end else if (state_q == S_SETTLE) begin
      if (scnt_q != '0) scnt_d = scnt_q - 1'b1;
    end else if (state_q == S_CHECK) begin
      if (mism) begin
        err_d = err_q + 1'b1;
        if (!fvalid_q) begin
          fvalid_d = 1'b1;
          fvec_d   = vec_q;
          fgot_d   = cell_out;
        end
      end
      // pass reflects this cycle's compare as well.
      if (state_d == S_DONE) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (err_d == '0);
      end else begin
        vec_d     = vec_q + 1'b1;
        cell_in_d = vec_q + 1'b1;
        scnt_d    = SRELOAD;
      end
    end
  end

  assign cell_in    = cell_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;
  assign fail_got   = fgot_q;

endmodule

// File: tb/tb_cell_bist.sv
// tb_cell_bist: scoreboard bench for cell_bist with a NAND2 truth table.
// Cell models are random truth tables; expectations come from a table walk.
module tb_cell_bist;

  localparam int          NIN    = 2;
  localparam int          NV     = 4;
  localparam logic [3:0]  TRUTH  = 4'b0111;
  localparam int          SETTLE = 2;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [NIN-1:0] cell_in;
  logic           cell_out;
  logic           busy;
  logic           done;
  logic           pass;
  logic [NIN:0]   err_count;
  logic           fail_valid;
  logic [NIN-1:0] fail_vec;
  logic           fail_got;
  logic [3:0]     model_tt;

  cell_bist #(
    .NIN   (NIN),
    .TRUTH (TRUTH),
    .SETTLE(SETTLE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .cell_in   (cell_in),
    .cell_out  (cell_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_valid(fail_valid),
    .fail_vec  (fail_vec),
    .fail_got  (fail_got)
  );

  assign cell_out = model_tt[cell_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c0;
    int done_cyc;
    int err;
    bit fvalid;
    int fvec;
    bit fgot;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   errors = 0;
  int   checks = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               name, got, want, cyc);
    end
  endtask

  // Walk the truth table: each visited vector costs SETTLE+1 cycles.
  function automatic exp_t predict(input logic [3:0] tt, input int c0);
    exp_t       e;
    logic [3:0] t;
    int         lastv;
    t = TRUTH;
    e.c0 = c0;
    e.err = 0;
    e.fvalid = 1'b0;
    e.fvec = 0;
    e.fgot = 1'b0;
    lastv = NV - 1;
    for (int v = 0; v < NV; v++) begin
      if (tt[v] != t[v]) begin
        if (!e.fvalid) begin
          e.fvalid = 1'b1;
          e.fvec = v;
          e.fgot = tt[v];
        end
        e.err++;
`ifdef CELL_BIST_STOP_ON_FAIL_EN
        lastv = v;
        break;
`endif
      end
    end
    e.done_cyc = c0 + (lastv + 1) * (SETTLE + 1);
    return e;
  endfunction

  always @(negedge clk) begin
    if (busy && q.size() > 0)
      chk("cell_in_seq", int'(cell_in),
          (cyc - q[0].c0) / (SETTLE + 1));
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        me = q.pop_front();
        chk("done_cycle", cyc, me.done_cyc);
        chk("busy_at_done", int'(busy), 0);
        chk("pass", int'(pass), int'(me.err == 0));
        chk("err_count", int'(err_count), me.err);
        chk("fail_valid", int'(fail_valid), int'(me.fvalid));
        if (me.fvalid) begin
          chk("fail_vec", int'(fail_vec), me.fvec);
          chk("fail_got", int'(fail_got), int'(me.fgot));
        end
      end
    end
    done_prev <= done;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic check_cleared();
    chk("zero_cell_in", int'(cell_in), 0);
    chk("zero_busy", int'(busy), 0);
    chk("zero_done", int'(done), 0);
    chk("zero_pass", int'(pass), 0);
    chk("zero_err", int'(err_count), 0);
    chk("zero_fvalid", int'(fail_valid), 0);
    chk("zero_fvec", int'(fail_vec), 0);
    chk("zero_fgot", int'(fail_got), 0);
  endtask

  task automatic run(input logic [3:0] tt, input bit poke);
    int c0;
    @(posedge clk);
    #1;
    model_tt = tt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    q.push_back(predict(tt, c0));
    chk("launch_busy", int'(busy), 1);
    chk("launch_done", int'(done), 0);
    chk("launch_err", int'(err_count), 0);
    chk("launch_fvalid", int'(fail_valid), 0);
    if (poke) begin
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic run_held(input logic [3:0] tt, input int n);
    exp_t e;
    int   c;
    int   clast;
    @(posedge clk);
    #1;
    model_tt = tt;
    start = 1'b1;
    @(posedge clk);
    #1;
    c = cyc;
    clast = c;
    for (int i = 0; i < n; i++) begin
      e = predict(tt, c);
      q.push_back(e);
      clast = c;
      c = e.done_cyc + 1;
    end
    while (cyc < clast) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle();
  endtask

  task automatic reset_mid_run();
    int c0;
    int n;
    @(posedge clk);
    #1;
    model_tt = TRUTH;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    q.push_back(predict(TRUTH, c0));
    n = 0;
    while (cell_in != 2'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec1", int'(cell_in), 1);
    reset_n = 1'b0;
    #1;
    q.delete();
    check_cleared();
    #3;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_cleared();
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    model_tt = TRUTH;
    repeat (2) @(negedge clk);
    check_cleared();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_cleared();

    run(4'b0111, 1'b0);
    run(4'b0001, 1'b0);
    run(4'b1111, 1'b0);
    run(4'b0111, 1'b1);
    run(4'b1110, 1'b1);
    for (int i = 0; i < 10; i++)
      run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    run_held(4'b0111, 3);
    run_held(4'b1010, 2);
    reset_mid_run();
    run(4'b0011, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
